// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage and IF/ID pipeline register: PC, redirect, stall and HLT handshake.
// Optional valid-fetch counter enabled by defining IF_FETCH_COUNT_EN.
module if_fetch_unit #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_target,
    input  logic        PC_update,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic        if_id_valid,
    output logic [3:0]  cntrl_opcode,
    output logic [2:0]  branch_cond,
    output logic [3:0]  load_save_reg,
    output logic [3:0]  reg_rs,
    output logic [3:0]  reg_rt_arith,
    output logic [3:0]  arith_imm,
    output logic [7:0]  load_save_imm,
    output logic [11:0] call_target,
    output logic [15:0] PC_out,
    output logic        halted,
    output logic [15:0] fetch_count
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [15:0] pcp1_q, pcp1_d;

    logic [15:0] pc_plus1;
    logic        is_hlt;

    assign pc_plus1 = pc_q + 16'd1;
    assign is_hlt   = (imem_data[15:12] == HLT_OPCODE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Redirect beats hazard; hazard freezes the FSM along with the datapath.
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = ST_RUN;
        end else if (!hazard) begin
            case (state_q)
                ST_RUN:  if (is_hlt)    state_d = ST_HALT;
                ST_HALT: if (PC_update) state_d = ST_RUN;
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_comb begin
        halted = (state_q == ST_HALT);
    end

    // NOTE: every next-state signal gets a hold default first, so no path infers a latch.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        pcp1_d  = pcp1_q;
        if (redirect_valid) begin
            pc_d    = redirect_target;
            instr_d = 16'h0000;
            valid_d = 1'b0;
        end else if (!hazard) begin
            case (state_q)
                ST_RUN: begin
                    instr_d = imem_data;
                    valid_d = 1'b1;
                    pcp1_d  = pc_plus1;
                    if (!is_hlt) pc_d = pc_plus1;
                end
                ST_HALT: begin
                    instr_d = 16'h0000;
                    valid_d = 1'b0;
                    if (PC_update) pc_d = pc_plus1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= RESET_PC;
            instr_q <= 16'h0000;
            valid_q <= 1'b0;
            pcp1_q  <= 16'h0000;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            pcp1_q  <= pcp1_d;
        end
    end

`ifdef IF_FETCH_COUNT_EN
    logic        fetch_load;
    logic [15:0] fetch_count_q;

    assign fetch_load = !redirect_valid && !hazard && (state_q == ST_RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_count_q <= 16'h0000;
        end else if (fetch_load && (fetch_count_q != 16'hFFFF)) begin
            fetch_count_q <= fetch_count_q + 16'd1;
        end
    end

    assign fetch_count = fetch_count_q;
`else
    assign fetch_count = 16'h0000;
`endif

    assign imem_addr     = pc_q;
    assign if_id_valid   = valid_q;
    assign PC_out        = pcp1_q;
    assign cntrl_opcode  = instr_q[15:12];
    assign branch_cond   = instr_q[10:8];
    assign load_save_reg = instr_q[11:8];
    assign reg_rs        = instr_q[7:4];
    assign reg_rt_arith  = instr_q[3:0];
    assign arith_imm     = instr_q[3:0];
    assign load_save_imm = instr_q[7:0];
    assign call_target   = instr_q[11:0];

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage and IF/ID pipeline register of the 16-bit pipelined core. It owns the program counter, drives the combinational instruction-memory address, and slices each fetched word into the fields the decode stage consumes. It honours the decode-stage hazard stall, control-flow redirects from later stages, and the HLT/PC_update halt handshake.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- HLT_OPCODE, 4'hF, opcode that halts fetch

- clk  in  1  global clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- hazard  in  1  decode-stage stall request; hold PC and IF/ID
- redirect_valid  in  1  branch taken / call / ret resolved this cycle
- redirect_target  in  16  next PC when redirect_valid=1
- PC_update  in  1  un-halt pulse from the PC updater
- imem_addr  out  16  instruction memory address (= PC, combinational)
- imem_data  in  16  instruction word, valid in the same cycle as imem_addr
- if_id_valid  out  1  IF/ID holds a real instruction (0 = bubble)
- cntrl_opcode  out  4  IF/ID instr[15:12]
- branch_cond  out  3  IF/ID instr[10:8]
- load_save_reg  out  4  IF/ID instr[11:8]
- reg_rs  out  4  IF/ID instr[7:4]
- reg_rt_arith  out  4  IF/ID instr[3:0]
- arith_imm  out  4  IF/ID instr[3:0]
- load_save_imm  out  8  IF/ID instr[7:0]
- call_target  out  12  IF/ID instr[11:0]
- PC_out  out  16  address of IF/ID instruction + 1
- halted  out  1  fetch is in HALT state
- fetch_count  out  16  valid-fetch counter (see Configuration)

## Operation
- Registers: PC[15:0], IF/ID instr[15:0], IF/ID valid, IF/ID pc_plus1[15:0], state {RUN, HALT}. All field outputs are slices of IF/ID instr.
- Bubble = instr 16'h0000, valid 0, pc_plus1 unchanged.
- PC+1 is 16-bit, wraps 16'hFFFF -> 16'h0000.
- Per-edge priority (highest first):
  1. redirect_valid=1: PC <= redirect_target; IF/ID <= bubble; state <= RUN (squashes a pending HLT, any state, overrides hazard).
  2. hazard=1: PC, IF/ID, state hold.
  3. RUN, imem_data[15:12] != HLT_OPCODE: IF/ID <= {imem_data, valid 1, PC+1}; PC <= PC+1.
  4. RUN, imem_data[15:12] == HLT_OPCODE: IF/ID <= {imem_data, valid 1, PC+1}; PC holds; state <= HALT.
  5. HALT, PC_update=1: PC <= PC+1; IF/ID <= bubble; state <= RUN.
  6. HALT, PC_update=0: PC holds; IF/ID <= bubble.
- PC_update in RUN is ignored.
- halted = (state == HALT).

## Timing
- Reset (rst=0, asynchronous): PC=RESET_PC, IF/ID instr=16'h0000, if_id_valid=0, PC_out=16'h0000, state=RUN, halted=0, fetch_count=0. All outputs hold these values while rst=0.
- First edge after rst deasserts fetches from RESET_PC.
- Fetch-to-decode latency: 1 cycle (word at imem_addr in cycle N appears on IF/ID outputs in N+1).
- Redirect: target on imem_addr the cycle after redirect_valid; target instruction on IF/ID two cycles after; exactly one bubble inserted.
- Stall: outputs bit-identical for every cycle hazard=1; fetch resumes with the same PC on the first edge with hazard=0.
- HLT: HLT appears in IF/ID with valid 1 the cycle after fetch; halted rises the same edge; PC_update sampled from the following cycle; fetch of HLT address+1 on the cycle after PC_update.
- Reset mid-stall or mid-halt: immediate return to reset values; no pending state survives.

## Configuration
- IF_FETCH_COUNT_EN defined: fetch_count increments by 1 on every edge that loads IF/ID with valid=1 (cases 3 and 4); saturates at 16'hFFFF; cleared only by reset.
- Not defined: no counter register; fetch_count tied to 16'h0000.

## Test plan
- Reset release, imem returns 16'h1234 at 0, 16'h2345 at 1 -> cycle 1: cntrl_opcode=1, reg_rs=3, reg_rt_arith=4, PC_out=0x0001, valid=1; cycle 2: opcode 2, PC_out=0x0002.
- hazard=1 for 3 cycles with PC=0x0010 -> imem_addr stays 0x0010, IF/ID unchanged; after release PC steps to 0x0011.
- redirect_valid=1, target 0x0ABC, simultaneous hazard=1 -> next cycle imem_addr=0x0ABC, if_id_valid=0; following cycle IF/ID holds word from 0x0ABC.
- HLT (16'hF000) at 0x0020 -> halted=1, imem_addr held 0x0020, bubbles thereafter; PC_update pulse -> imem_addr=0x0021, halted=0.
- In HALT, redirect_valid=1 target 0x0100 -> halted=0, imem_addr=0x0100, one bubble.
- PC=0xFFFF, no stall -> next imem_addr=0x0000, PC_out=0x0000; with IF_FETCH_COUNT_EN, fetch_count preset via 65535 fetches stays 16'hFFFF on the next fetch; without macro fetch_count=0 throughout.
